// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the RISC-V pipeline. It keeps a
// shadow copy of the in-flight destination registers: the EX stage (stage 0)
// and DEPTH later producer stages (1 = MEM, 2 = WB, ...).
//
// From that copy it computes two things:
//   - the operand forward selects for the instruction currently in EX;
//   - a stall for the instruction in ID when a load it depends on cannot
//     deliver its data in time.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   hold          whole pipeline frozen this cycle
//   flush         kill the instructions in ID and EX
//   id_valid      ID holds a real instruction
//   id_rs         ID source registers, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_rd         ID destination register
//   id_regwrite   ID instruction writes id_rd
//   id_is_load    ID instruction is a load
//   fwd_sel       per EX operand: 0 = register file, k = forward from stage k
//   stall         hold PC and IF/ID, insert a bubble into EX
//   stall_cnt     saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1),
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_is_load,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cnt
);

    // A load sitting in EX is never forwardable to the very next instruction
    // unless load data is already available at stage 1 or earlier.
    localparam bit EX_LOAD_LATE = (LOAD_STAGE > 1);

    // Stage 0 (EX) entry.
    logic                          ex_valid;
    logic [REG_ADDR_W-1:0]         ex_rd;
    logic                          ex_regwrite;
    logic                          ex_is_load;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;

    // Producer stages 1..DEPTH.
    logic [DEPTH:1]                p_valid;
    logic [DEPTH:1]                p_regwrite;
    logic [DEPTH:1]                p_is_load;
    logic [REG_ADDR_W-1:0]         p_rd [1:DEPTH];

    logic [NUM_SRC-1:0]            haz;

    // Forward selects: the descending scan lets the youngest match overwrite
    // any older one.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_ADDR_W-1:0] src;
            src = ex_rs[i*REG_ADDR_W +: REG_ADDR_W];
            for (int k = DEPTH; k >= 1; k--) begin
                if (ex_valid && (src != '0) && p_valid[k] && p_regwrite[k] &&
                    (p_rd[k] == src)) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    // Load-use detection over stages 0..DEPTH-1. Again the youngest match
    // decides; a younger non-load producer masks an older late load.
    always_comb begin
        haz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_ADDR_W-1:0] src;
            src = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
            for (int j = DEPTH - 1; j >= 1; j--) begin
                if (p_valid[j] && p_regwrite[j] && (p_rd[j] == src) &&
                    (src != '0)) begin
                    haz[i] = p_is_load[j] && ((j + 1) < LOAD_STAGE);
                end
            end
            if (ex_valid && ex_regwrite && (ex_rd == src) && (src != '0)) begin
                haz[i] = ex_is_load && EX_LOAD_LATE;
            end
        end
        stall = id_valid && !flush && (|haz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_rs       <= '0;
            p_valid     <= '0;
            p_regwrite  <= '0;
            p_is_load   <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                p_rd[k] <= '0;
            end
            stall_cnt   <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                p_valid[k]    <= p_valid[k-1];
                p_regwrite[k] <= p_regwrite[k-1];
                p_is_load[k]  <= p_is_load[k-1];
                p_rd[k]       <= p_rd[k-1];
            end
            // A flushed EX instruction must never become a producer.
            p_valid[1]    <= ex_valid && !flush;
            p_regwrite[1] <= ex_regwrite;
            p_is_load[1]  <= ex_is_load;
            p_rd[1]       <= ex_rd;

            if (!stall && !flush) begin
                ex_valid    <= id_valid;
                ex_rd       <= id_rd;
                ex_regwrite <= id_regwrite;
                ex_is_load  <= id_is_load;
                ex_rs       <= id_rs;
            end else begin
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_is_load  <= 1'b0;
                ex_rs       <= '0;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed vector table, reset/saturation
// sequences and randomized traffic checked against an instruction-history
// model of the pipeline.
module tb_fwd_hazard_unit;

    localparam int RW = 5;
    localparam int NS = 2;
    localparam int D  = 2;
    localparam int LS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        id_is_load = 1'b0;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;
    logic [3:0]  fwd_sel4;
    logic        stall4;
    logic [3:0]  stall_cnt4;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy so counter saturation is reachable quickly.
    fwd_hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .fwd_sel(fwd_sel4), .stall(stall4), .stall_cnt(stall_cnt4)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // ---------------- reference model: history of what entered EX ----------
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
        bit [4:0] rs0;
        bit [4:0] rs1;
    } ent_t;

    ent_t        m_ex;
    ent_t        m_hist[$];   // m_hist[k-1] is the producer k edges older than EX
    int unsigned m_cnt;
    int unsigned m_cnt4;

    function automatic ent_t empty_ent();
        ent_t e;
        e = '{v: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, rs0: 5'd0, rs1: 5'd0};
        return e;
    endfunction

    function automatic void m_reset();
        m_ex = empty_ent();
        m_hist.delete();
        for (int k = 0; k < D; k++) m_hist.push_back(empty_ent());
        m_cnt  = 0;
        m_cnt4 = 0;
    endfunction

    function automatic bit m_match(ent_t e, bit [4:0] r);
        return e.v && e.rw && (e.rd == r) && (r != 0);
    endfunction

    function automatic int m_fwd(bit [4:0] r);
        if (!m_ex.v || r == 0) return 0;
        for (int k = 1; k <= D; k++)
            if (m_match(m_hist[k-1], r)) return k;
        return 0;
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush) return 0;
        for (int i = 0; i < NS; i++) begin
            bit [4:0] r;
            bit       found;
            r = id_rs[i*RW +: RW];
            found = 0;
            for (int j = 0; j < D && !found; j++) begin
                ent_t e;
                e = (j == 0) ? m_ex : m_hist[j-1];
                if (m_match(e, r)) begin
                    found = 1;
                    if (e.ld && (j + 1 < LS)) return 1;
                end
            end
        end
        return 0;
    endfunction

    task automatic check_model();
        chk("fwd0", 32'(fwd_sel[1:0]), 32'(m_fwd(m_ex.rs0)));
        chk("fwd1", 32'(fwd_sel[3:2]), 32'(m_fwd(m_ex.rs1)));
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("stall_cnt", 32'(stall_cnt), m_cnt);
        chk("stall_cnt4", 32'(stall_cnt4), m_cnt4);
    endtask

    // Called after the negedge check: clocks one edge and updates the model.
    task automatic advance();
        bit   st;
        bit   h;
        bit   f;
        ent_t nxt;
        ent_t moving;
        st = m_stall();
        h  = hold;
        f  = flush;
        nxt = '{v: id_valid, rd: id_rd, rw: id_regwrite, ld: id_is_load,
                rs0: id_rs[4:0], rs1: id_rs[9:5]};
        @(posedge clk);
        if (!h) begin
            moving = m_ex;
            if (f) moving.v = 0;
            m_hist.push_front(moving);
            void'(m_hist.pop_back());
            m_ex = (!st && !f) ? nxt : empty_ent();
            if (st && m_cnt != 32'hFFFF) m_cnt++;
            if (st && m_cnt4 != 15) m_cnt4++;
        end
        #1;
    endtask

    task automatic drive(input bit h, input bit f, input bit iv, input bit [4:0] r0,
                         input bit [4:0] r1, input bit [4:0] rd, input bit rw, input bit ld);
        hold = h; flush = f; id_valid = iv;
        id_rs = {r1, r0}; id_rd = rd; id_regwrite = rw; id_is_load = ld;
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        bit        h, f, iv;
        bit [4:0]  r0, r1, rd;
        bit        rw, ld;
        bit [1:0]  e0, e1;
        bit        est;
        bit [15:0] ecnt;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(bit h, bit f, bit iv, bit [4:0] r0, bit [4:0] r1,
                                bit [4:0] rd, bit rw, bit ld, bit [1:0] e0,
                                bit [1:0] e1, bit est, bit [15:0] ecnt);
        vec_t v;
        v = '{h: h, f: f, iv: iv, r0: r0, r1: r1, rd: rd, rw: rw, ld: ld,
              e0: e0, e1: e1, est: est, ecnt: ecnt};
        return v;
    endfunction

    initial begin
        //            h f iv r0 r1 rd rw ld  e0 e1 st cnt
        tbl[0]  = mk(0,0,1, 1, 2, 5, 1,0,  0, 0, 0, 0);  // add x5
        tbl[1]  = mk(0,0,1, 5, 5, 6, 1,0,  0, 0, 0, 0);  // sub x6,x5,x5
        tbl[2]  = mk(0,0,0, 0, 0, 0, 0,0,  1, 1, 0, 0);
        tbl[3]  = mk(0,0,1, 1, 2, 5, 1,0,  0, 0, 0, 0);  // add x5
        tbl[4]  = mk(0,0,1, 3, 4, 9, 1,0,  0, 0, 0, 0);  // unrelated
        tbl[5]  = mk(0,0,1, 5, 5, 6, 1,0,  0, 0, 0, 0);  // sub x6,x5,x5
        tbl[6]  = mk(0,0,0, 0, 0, 0, 0,0,  2, 2, 0, 0);
        tbl[7]  = mk(0,0,1, 1, 2, 0, 1,0,  0, 0, 0, 0);  // add x0
        tbl[8]  = mk(0,0,1, 0, 0, 6, 1,0,  0, 0, 0, 0);  // uses x0
        tbl[9]  = mk(0,0,0, 0, 0, 0, 0,0,  0, 0, 0, 0);
        tbl[10] = mk(0,0,1, 1, 2, 5, 1,0,  0, 0, 0, 0);  // add x5
        tbl[11] = mk(0,0,1, 3, 4, 5, 1,0,  0, 0, 0, 0);  // or x5
        tbl[12] = mk(0,0,1, 5, 1, 6, 1,0,  0, 0, 0, 0);  // use x5
        tbl[13] = mk(0,0,0, 0, 0, 0, 0,0,  1, 0, 0, 0);  // youngest wins
        tbl[14] = mk(0,0,1, 1, 0, 7, 1,1,  0, 0, 0, 0);  // lw x7
        tbl[15] = mk(0,0,1, 7, 1, 8, 1,0,  0, 0, 1, 0);  // add x8,x7,x1
        tbl[16] = mk(0,0,1, 7, 1, 8, 1,0,  0, 0, 0, 1);
        tbl[17] = mk(0,0,0, 0, 0, 0, 0,0,  2, 0, 0, 1);
        tbl[18] = mk(0,0,1, 1, 0, 7, 1,1,  0, 0, 0, 1);  // lw x7
        tbl[19] = mk(0,1,1, 7, 1, 8, 1,0,  0, 0, 0, 1);  // dependent + flush
        tbl[20] = mk(0,0,1, 7, 7, 9, 1,0,  0, 0, 0, 1);  // use x7
        tbl[21] = mk(0,0,0, 0, 0, 0, 0,0,  0, 0, 0, 1);  // killed lw invisible
        tbl[22] = mk(0,0,0, 0, 0, 0, 0,0,  0, 0, 0, 1);
        tbl[23] = mk(0,0,1, 1, 0, 7, 1,1,  0, 0, 0, 1);  // lw x7
        tbl[24] = mk(1,0,1, 7, 1, 8, 1,0,  0, 0, 1, 1);  // held stall
        tbl[25] = mk(1,0,1, 7, 1, 8, 1,0,  0, 0, 1, 1);
        tbl[26] = mk(1,0,1, 7, 1, 8, 1,0,  0, 0, 1, 1);
        tbl[27] = mk(0,0,1, 7, 1, 8, 1,0,  0, 0, 1, 1);
        tbl[28] = mk(0,0,1, 7, 1, 8, 1,0,  0, 0, 0, 2);
        tbl[29] = mk(0,0,0, 0, 0, 0, 0,0,  2, 0, 0, 2);

        m_reset();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            drive(tbl[n].h, tbl[n].f, tbl[n].iv, tbl[n].r0, tbl[n].r1,
                  tbl[n].rd, tbl[n].rw, tbl[n].ld);
            @(negedge clk);
            chk($sformatf("tbl%0d_fwd0", n), 32'(fwd_sel[1:0]), 32'(tbl[n].e0));
            chk($sformatf("tbl%0d_fwd1", n), 32'(fwd_sel[3:2]), 32'(tbl[n].e1));
            chk($sformatf("tbl%0d_stall", n), 32'(stall), 32'(tbl[n].est));
            chk($sformatf("tbl%0d_cnt", n), 32'(stall_cnt), 32'(tbl[n].ecnt));
            check_model();
            advance();
        end

        // Reset asserted mid-cycle with valid entries, a live forward and a stall.
        drive(0,0,1, 2, 3, 1, 1,0); @(negedge clk); check_model(); advance(); // add x1
        drive(0,0,1, 1, 0, 7, 1,1); @(negedge clk); check_model(); advance(); // lw x7,(x1)
        drive(0,0,1, 7, 1, 8, 1,0);                                            // add x8,x7,x1
        @(negedge clk);
        chk("pre_rst_fwd", 32'(fwd_sel), 32'(4'b0001));
        chk("pre_rst_stall", 32'(stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_fwd", 32'(fwd_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        m_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back dependent loads: one stall every other cycle.
        for (int n = 0; n < 40; n++) begin
            drive(0,0,1, 7, 0, 7, 1,1);
            @(negedge clk);
            check_model();
            advance();
        end
        chk("cnt_after_chain", 32'(stall_cnt), 32'd20);
        chk("cnt4_saturated", 32'(stall_cnt4), 32'd15);

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0);
            @(negedge clk);
            check_model();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
